// File: rtl/dcache_pkg.sv
// Shared widths, entry layout and FSM encoding for the data-cache tag array.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package dcache_pkg;

  // Controller states: SWEEP clears one set per cycle, READY serves traffic.
  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_READY = 1'b1
  } dc_state_e;

  function automatic int calc_off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int calc_idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int calc_tag_w(input int addr_width, input int sets, input int line_bytes);
    return addr_width - $clog2(sets) - $clog2(line_bytes);
  endfunction

  // A direct-mapped cache still carries a 1-bit way field on its ports.
  function automatic int calc_way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Tree PLRU needs WAYS-1 bits; keep one dummy bit when WAYS=1 so arrays stay legal.
  function automatic int calc_plru_w(input int ways);
    return (ways > 1) ? ways - 1 : 1;
  endfunction

  // Entry layout is {dirty, valid, tag} with the tag in the low bits.
  function automatic int calc_entry_w(input int tag_w);
    return tag_w + 2;
  endfunction

  function automatic int entry_valid_pos(input int tag_w);
    return tag_w;
  endfunction

  function automatic int entry_dirty_pos(input int tag_w);
    return tag_w + 1;
  endfunction

endpackage

// File: rtl/dcache_plru.sv
// Tree pseudo-LRU for one set: replacement candidate and the state after touching a way.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the returned state is stored.
module dcache_plru
  import dcache_pkg::*;
#(
  parameter int  WAYS   = 2,
  localparam int WAY_W  = calc_way_w(WAYS),
  localparam int PLRU_W = calc_plru_w(WAYS)
) (
  input  logic [PLRU_W-1:0] plru_i,
  input  logic [WAY_W-1:0]  touch_way_i,
  output logic [WAY_W-1:0]  victim_way_o,
  output logic [PLRU_W-1:0] plru_next_o
);

  // Each node bit points toward the half holding the less-recently-used way.
  if (WAYS == 4) begin : g_four
    // bit 0 = root, bit 1 = ways 0/1 node, bit 2 = ways 2/3 node
    always_comb begin
      victim_way_o   = plru_i[0] ? {1'b1, plru_i[2]} : {1'b0, plru_i[1]};
      plru_next_o    = plru_i;
      plru_next_o[0] = ~touch_way_i[1];
      if (touch_way_i[1]) begin
        plru_next_o[2] = ~touch_way_i[0];
      end else begin
        plru_next_o[1] = ~touch_way_i[0];
      end
    end
  end else if (WAYS == 2) begin : g_two
    // Single node: point at the way that was not touched.
    always_comb begin
      victim_way_o = plru_i;
      plru_next_o  = ~touch_way_i;
    end
  end else begin : g_one
    // Direct-mapped: only one candidate, state never changes.
    always_comb begin
      victim_way_o = '0;
      plru_next_o  = plru_i;
    end
  end

endmodule

// File: rtl/dcache_tag_array.sv
// Set-associative tag store: hit/victim report per lookup, entry updates, set-by-set clear sweep.
// Latency: response and victim fields one cycle after an accepted lookup; a sweep lasts SETS cycles.
// Backpressure: lookups stall (ready low) while sweeping or while an update is presented.
module dcache_tag_array
  import dcache_pkg::*;
#(
  parameter int  ADDR_WIDTH = 32,
  parameter int  SETS       = 64,
  parameter int  WAYS       = 2,
  parameter int  LINE_BYTES = 64,
  localparam int OFF_W      = calc_off_w(LINE_BYTES),
  localparam int IDX_W      = calc_idx_w(SETS),
  localparam int TAG_W      = calc_tag_w(ADDR_WIDTH, SETS, LINE_BYTES),
  localparam int WAY_W      = calc_way_w(WAYS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  lookup_valid_i,
  input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
  output logic                  lookup_ready_o,
  output logic                  resp_valid_o,
  output logic                  resp_hit_o,
  output logic [WAY_W-1:0]      resp_way_o,
  output logic                  resp_dirty_o,
  output logic [WAY_W-1:0]      victim_way_o,
  output logic                  victim_valid_o,
  output logic                  victim_dirty_o,
  output logic [TAG_W-1:0]      victim_tag_o,
  input  logic                  upd_valid_i,
  input  logic [ADDR_WIDTH-1:0] upd_addr_i,
  input  logic [WAY_W-1:0]      upd_way_i,
  input  logic                  upd_vbit_i,
  input  logic                  upd_dbit_i,
  input  logic                  flush_i,
  output logic                  busy_o
);

  localparam int ENTRY_W = calc_entry_w(TAG_W);
  localparam int V_POS   = entry_valid_pos(TAG_W);
  localparam int D_POS   = entry_dirty_pos(TAG_W);
  localparam int PLRU_W  = calc_plru_w(WAYS);

  dc_state_e state_q, state_d;
  logic [IDX_W-1:0] sweep_cnt_q, sweep_cnt_d;

  // Storage has no reset: the sweep that follows every reset clears it.
  logic [ENTRY_W-1:0] tag_mem  [SETS][WAYS];
  logic [PLRU_W-1:0]  plru_mem [SETS];

  logic [IDX_W-1:0] lk_idx, upd_idx, plru_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             sweep_active, lookup_fire, upd_fire, upd_way_ok;

  logic               hit, hit_dirty, inv_found;
  logic [WAY_W-1:0]   hit_way, inv_way, plru_victim, vic_way, touch_way;
  logic [ENTRY_W-1:0] vic_entry;
  logic [PLRU_W-1:0]  plru_cur, plru_next;

  // Line offset bits never matter to the tag store.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{lookup_addr_i[OFF_W-1:0], upd_addr_i[OFF_W-1:0]};

  assign lk_idx  = lookup_addr_i[OFF_W +: IDX_W];
  assign lk_tag  = lookup_addr_i[OFF_W+IDX_W +: TAG_W];
  assign upd_idx = upd_addr_i[OFF_W +: IDX_W];
  assign upd_tag = upd_addr_i[OFF_W+IDX_W +: TAG_W];

  assign sweep_active = (state_q == ST_SWEEP);
  assign upd_way_ok   = (int'(upd_way_i) < WAYS);
  assign upd_fire     = upd_valid_i && (state_q == ST_READY) && upd_way_ok;
  assign lookup_fire  = lookup_valid_i && lookup_ready_o;

  // FSM state and sweep index register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_SWEEP;
      sweep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  // Next state plus busy/ready; an update in flight takes priority over a lookup.
  always_comb begin
    state_d        = state_q;
    sweep_cnt_d    = sweep_cnt_q;
    busy_o         = 1'b0;
    lookup_ready_o = 1'b0;
    unique case (state_q)
      ST_SWEEP: begin
        busy_o = 1'b1;
        if (sweep_cnt_q == IDX_W'(SETS - 1)) begin
          state_d     = ST_READY;
          sweep_cnt_d = '0;
        end else begin
          sweep_cnt_d = sweep_cnt_q + IDX_W'(1);
        end
      end
      ST_READY: begin
        lookup_ready_o = !upd_valid_i;
        if (flush_i) begin
          state_d     = ST_SWEEP;
          sweep_cnt_d = '0;
        end
      end
    endcase
  end

  // Tag compare (lowest matching way wins) and lowest invalid way for replacement.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    hit_dirty = 1'b0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && tag_mem[lk_idx][w][V_POS] && (tag_mem[lk_idx][w][TAG_W-1:0] == lk_tag)) begin
        hit       = 1'b1;
        hit_way   = WAY_W'(w);
        hit_dirty = tag_mem[lk_idx][w][D_POS];
      end
      if (!inv_found && !tag_mem[lk_idx][w][V_POS]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  // One PLRU port serves both users: updates and lookups never fire in the same cycle.
  assign plru_idx  = upd_valid_i ? upd_idx : lk_idx;
  assign touch_way = upd_valid_i ? upd_way_i : hit_way;
  assign plru_cur  = plru_mem[plru_idx];

  dcache_plru #(
    .WAYS (WAYS)
  ) u_plru (
    .plru_i       (plru_cur),
    .touch_way_i  (touch_way),
    .victim_way_o (plru_victim),
    .plru_next_o  (plru_next)
  );

  assign vic_way   = inv_found ? inv_way : plru_victim;
  assign vic_entry = tag_mem[lk_idx][vic_way];

  // Array writes: sweep clears a whole set; otherwise apply updates and PLRU touches.
  always_ff @(posedge clk_i) begin
    if (sweep_active) begin
      for (int w = 0; w < WAYS; w++) begin
        tag_mem[sweep_cnt_q][w] <= '0;
      end
      plru_mem[sweep_cnt_q] <= '0;
    end else begin
      if (upd_fire) begin
        tag_mem[upd_idx][upd_way_i] <= {upd_dbit_i, upd_vbit_i, upd_tag};
      end
      if (upd_fire && upd_vbit_i) begin
        plru_mem[upd_idx] <= plru_next;
      end else if (lookup_fire && hit) begin
        plru_mem[lk_idx] <= plru_next;
      end
    end
  end

  // Response/victim registers capture array state at the accept edge and hold otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_o   <= 1'b0;
      resp_hit_o     <= 1'b0;
      resp_way_o     <= '0;
      resp_dirty_o   <= 1'b0;
      victim_way_o   <= '0;
      victim_valid_o <= 1'b0;
      victim_dirty_o <= 1'b0;
      victim_tag_o   <= '0;
    end else begin
      resp_valid_o <= lookup_fire;
      if (lookup_fire) begin
        resp_hit_o     <= hit;
        resp_way_o     <= hit_way;
        resp_dirty_o   <= hit_dirty;
        victim_way_o   <= vic_way;
        victim_valid_o <= vic_entry[V_POS];
        victim_dirty_o <= vic_entry[D_POS];
        victim_tag_o   <= vic_entry[TAG_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_dcache_tag_array.sv
// Bench for the tag array (64 sets, 2 ways, 64-byte lines) against an LRU reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_dcache_tag_array;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        lookup_valid_i;
  logic [31:0] lookup_addr_i;
  logic        lookup_ready_o;
  logic        resp_valid_o;
  logic        resp_hit_o;
  logic [0:0]  resp_way_o;
  logic        resp_dirty_o;
  logic [0:0]  victim_way_o;
  logic        victim_valid_o;
  logic        victim_dirty_o;
  logic [19:0] victim_tag_o;
  logic        upd_valid_i;
  logic [31:0] upd_addr_i;
  logic [0:0]  upd_way_i;
  logic        upd_vbit_i;
  logic        upd_dbit_i;
  logic        flush_i;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  dcache_tag_array #(
    .ADDR_WIDTH (32),
    .SETS       (64),
    .WAYS       (2),
    .LINE_BYTES (64)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .lookup_valid_i (lookup_valid_i),
    .lookup_addr_i  (lookup_addr_i),
    .lookup_ready_o (lookup_ready_o),
    .resp_valid_o   (resp_valid_o),
    .resp_hit_o     (resp_hit_o),
    .resp_way_o     (resp_way_o),
    .resp_dirty_o   (resp_dirty_o),
    .victim_way_o   (victim_way_o),
    .victim_valid_o (victim_valid_o),
    .victim_dirty_o (victim_dirty_o),
    .victim_tag_o   (victim_tag_o),
    .upd_valid_i    (upd_valid_i),
    .upd_addr_i     (upd_addr_i),
    .upd_way_i      (upd_way_i),
    .upd_vbit_i     (upd_vbit_i),
    .upd_dbit_i     (upd_dbit_i),
    .flush_i        (flush_i),
    .busy_o         (busy_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: per-way contents plus the most-recently-used way of each set.
  bit          m_valid [64][2];
  bit          m_dirty [64][2];
  bit          m_known [64][2];
  int unsigned m_tag   [64][2];
  int          m_mru   [64];

  logic        exp_hit, exp_dirty, exp_vvalid, exp_vdirty, exp_vtag_known;
  logic [0:0]  exp_way, exp_vway;
  logic [19:0] exp_vtag;

  logic        obs_rdy, obs_rv, obs_hit, obs_dirty, obs_vvalid, obs_vdirty;
  logic [0:0]  obs_way, obs_vway;
  logic [19:0] obs_vtag;

  function automatic int set_of(input logic [31:0] a);
    return int'((a / 64) % 64);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a / 4096;
  endfunction

  function automatic void model_sweep();
    for (int s = 0; s < 64; s++) begin
      m_mru[s] = -1;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_known[s][w] = 1'b0;
        m_tag[s][w]   = 0;
      end
    end
  endfunction

  function automatic void model_update(input logic [31:0] a, input int w, input bit v, input bit d);
    int s;
    s = set_of(a);
    m_valid[s][w] = v;
    m_dirty[s][w] = d;
    m_tag[s][w]   = tag_of(a);
    m_known[s][w] = 1'b1;
    if (v) m_mru[s] = w;
  endfunction

  // Expected response for a lookup; a hit makes its way most recently used.
  function automatic void model_lookup(input logic [31:0] a);
    int s, hw, vw;
    s  = set_of(a);
    hw = -1;
    vw = -1;
    for (int w = 0; w < 2; w++) begin
      if (hw < 0 && m_valid[s][w] && m_tag[s][w] == tag_of(a)) hw = w;
      if (vw < 0 && !m_valid[s][w]) vw = w;
    end
    if (vw < 0) vw = (m_mru[s] == 0) ? 1 : 0;
    exp_hit        = (hw >= 0);
    exp_way        = (hw >= 0) ? 1'(hw) : 1'b0;
    exp_dirty      = (hw >= 0) ? m_dirty[s][hw] : 1'b0;
    exp_vway       = 1'(vw);
    exp_vvalid     = m_valid[s][vw];
    exp_vdirty     = m_dirty[s][vw];
    exp_vtag       = 20'(m_tag[s][vw]);
    exp_vtag_known = m_known[s][vw];
    if (hw >= 0) m_mru[s] = hw;
  endfunction

  task automatic do_lookup(input logic [31:0] a);
    @(posedge clk_i); #1;
    lookup_valid_i = 1'b1;
    lookup_addr_i  = a;
    #1;
    obs_rdy = lookup_ready_o;
    @(posedge clk_i); #1;
    lookup_valid_i = 1'b0;
    obs_rv     = resp_valid_o;
    obs_hit    = resp_hit_o;
    obs_way    = resp_way_o;
    obs_dirty  = resp_dirty_o;
    obs_vway   = victim_way_o;
    obs_vvalid = victim_valid_o;
    obs_vdirty = victim_dirty_o;
    obs_vtag   = victim_tag_o;
  endtask

  task automatic do_update(input logic [31:0] a, input int w, input bit v, input bit d);
    @(posedge clk_i); #1;
    upd_valid_i = 1'b1;
    upd_addr_i  = a;
    upd_way_i   = 1'(w);
    upd_vbit_i  = v;
    upd_dbit_i  = d;
    @(posedge clk_i); #1;
    upd_valid_i = 1'b0;
    model_update(a, w, v, d);
  endtask

  task automatic test_reset();
    int n;
    bit bad;
    rst_ni = 1'b0; lookup_valid_i = 1'b0; lookup_addr_i = '0; upd_valid_i = 1'b0;
    upd_addr_i = '0; upd_way_i = '0; upd_vbit_i = 1'b0; upd_dbit_i = 1'b0; flush_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    lookup_valid_i = 1'b1;
    #1;
    n_checks++; if (busy_o !== 1'b1) $display("FAIL reset_busy got %0b want 1", busy_o); else n_pass++;
    n_checks++; if (lookup_ready_o !== 1'b0) $display("FAIL reset_ready got %0b want 0", lookup_ready_o); else n_pass++;
    n_checks++;
    if ({resp_valid_o, resp_hit_o, resp_way_o, resp_dirty_o, victim_way_o, victim_valid_o, victim_dirty_o, victim_tag_o} !== '0)
      $display("FAIL reset_outputs got %h want 0", {resp_valid_o, resp_hit_o, resp_way_o, resp_dirty_o,
               victim_way_o, victim_valid_o, victim_dirty_o, victim_tag_o});
    else n_pass++;
    lookup_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    n = 0; bad = 1'b0;
    while (busy_o === 1'b1 && n < 200) begin
      if (lookup_ready_o !== 1'b0) bad = 1'b1;
      n++;
      @(posedge clk_i); #1;
    end
    n_checks++; if (n != 64) $display("FAIL init_sweep_len got %0d want 64", n); else n_pass++;
    n_checks++; if (bad) $display("FAIL init_ready_during_sweep got 1 want 0"); else n_pass++;
    n_checks++; if (lookup_ready_o !== 1'b1) $display("FAIL init_ready_after got %0b want 1", lookup_ready_o); else n_pass++;
    model_sweep();
  endtask

  task automatic test_miss_after_init();
    do_lookup(32'h0000_1040);
    model_lookup(32'h0000_1040);
    n_checks++; if (obs_rdy !== 1'b1) $display("FAIL init_lookup_ready got %0b want 1", obs_rdy); else n_pass++;
    n_checks++; if (obs_rv !== 1'b1) $display("FAIL init_lookup_rv got %0b want 1", obs_rv); else n_pass++;
    n_checks++; if (obs_hit !== 1'b0) $display("FAIL init_lookup_hit got %0b want 0", obs_hit); else n_pass++;
    n_checks++;
    if ({obs_vway, obs_vvalid} !== 2'b00) $display("FAIL init_victim got way %0d valid %0b want way 0 valid 0", obs_vway, obs_vvalid);
    else n_pass++;
  endtask

  task automatic test_hit_dirty();
    do_update(32'h0000_1040, 1, 1'b1, 1'b1);
    do_lookup(32'h0000_1040);
    model_lookup(32'h0000_1040);
    n_checks++;
    if ({obs_rv, obs_hit, obs_way, obs_dirty} !== 4'b1111)
      $display("FAIL hit_dirty got rv %0b hit %0b way %0d dirty %0b want 1 1 1 1", obs_rv, obs_hit, obs_way, obs_dirty);
    else n_pass++;
    do_lookup(32'h0000_2040);
    model_lookup(32'h0000_2040);
    n_checks++;
    if ({obs_hit, obs_way, obs_dirty, obs_vway} !== 4'b0000)
      $display("FAIL miss_victim got hit %0b way %0d dirty %0b vway %0d want 0 0 0 0", obs_hit, obs_way, obs_dirty, obs_vway);
    else n_pass++;
  endtask

  task automatic test_plru_victim();
    do_update(32'h0000_1040, 0, 1'b1, 1'b0);
    do_update(32'h0000_2040, 1, 1'b1, 1'b0);
    do_lookup(32'h0000_1040);
    model_lookup(32'h0000_1040);
    n_checks++;
    if ({obs_hit, obs_way} !== 2'b10) $display("FAIL plru_hit got hit %0b way %0d want 1 0", obs_hit, obs_way); else n_pass++;
    do_lookup(32'h0000_3040);
    model_lookup(32'h0000_3040);
    n_checks++; if (obs_hit !== 1'b0) $display("FAIL plru_miss got %0b want 0", obs_hit); else n_pass++;
    n_checks++; if (obs_vway !== 1'b1) $display("FAIL plru_victim_way got %0d want 1", obs_vway); else n_pass++;
    n_checks++; if (obs_vtag !== 20'h00002) $display("FAIL plru_victim_tag got %h want 00002", obs_vtag); else n_pass++;
    n_checks++; if (obs_vvalid !== 1'b1) $display("FAIL plru_victim_valid got %0b want 1", obs_vvalid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    a = 32'h0000_7140;
    b = 32'h0000_3140;
    @(posedge clk_i); #1;
    upd_valid_i = 1'b1; upd_addr_i = a; upd_way_i = 1'b0; upd_vbit_i = 1'b1; upd_dbit_i = 1'b0;
    lookup_valid_i = 1'b1; lookup_addr_i = a;
    #1;
    n_checks++; if (lookup_ready_o !== 1'b0) $display("FAIL conflict_ready got %0b want 0", lookup_ready_o); else n_pass++;
    @(posedge clk_i); #1;
    upd_valid_i = 1'b0;
    model_update(a, 0, 1'b1, 1'b0);
    n_checks++; if (resp_valid_o !== 1'b0) $display("FAIL conflict_no_resp got %0b want 0", resp_valid_o); else n_pass++;
    #1;
    n_checks++; if (lookup_ready_o !== 1'b1) $display("FAIL conflict_ready_next got %0b want 1", lookup_ready_o); else n_pass++;
    model_lookup(a);
    @(posedge clk_i); #1;
    lookup_addr_i = b;
    n_checks++;
    if ({resp_valid_o, resp_hit_o, resp_way_o, resp_dirty_o} !== {1'b1, exp_hit, exp_way, exp_dirty} || exp_hit !== 1'b1)
      $display("FAIL b2b_first got %b want 1%b%b%b", {resp_hit_o, resp_way_o, resp_dirty_o}, exp_hit, exp_way, exp_dirty);
    else n_pass++;
    model_lookup(b);
    @(posedge clk_i); #1;
    lookup_valid_i = 1'b0;
    n_checks++;
    if ({resp_valid_o, resp_hit_o, victim_way_o, victim_valid_o} !== {1'b1, exp_hit, exp_vway, exp_vvalid})
      $display("FAIL b2b_second got %b want 1%b%b%b", {resp_hit_o, victim_way_o, victim_valid_o}, exp_hit, exp_vway, exp_vvalid);
    else n_pass++;
  endtask

  task automatic test_hold();
    do_lookup(32'h0000_1040);
    model_lookup(32'h0000_1040);
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++; if (resp_valid_o !== 1'b0) $display("FAIL hold_rv got %0b want 0", resp_valid_o); else n_pass++;
    n_checks++;
    if ({resp_hit_o, resp_way_o, resp_dirty_o, victim_way_o, victim_tag_o} !== {obs_hit, obs_way, obs_dirty, obs_vway, obs_vtag})
      $display("FAIL hold_fields got %h want %h", {resp_hit_o, resp_way_o, resp_dirty_o, victim_way_o, victim_tag_o},
               {obs_hit, obs_way, obs_dirty, obs_vway, obs_vtag});
    else n_pass++;
  endtask

  task automatic test_random();
    int s, op;
    longint t;
    logic [31:0] a;
    for (int i = 0; i < 300; i++) begin
      s  = ($urandom_range(0, 7) == 0) ? 63 : int'($urandom_range(0, 3));
      t  = ($urandom_range(0, 7) == 0) ? 64'hF_FFFF : longint'($urandom_range(0, 3));
      a  = 32'(t * 4096 + s * 64 + longint'($urandom_range(0, 63)));
      op = int'($urandom_range(0, 9));
      if (op < 6) begin
        do_lookup(a);
        model_lookup(a);
        n_checks++;
        if ({obs_rdy, obs_rv} !== 2'b11) $display("FAIL rand_accept got rdy %0b rv %0b want 1 1", obs_rdy, obs_rv); else n_pass++;
        n_checks++;
        if ({obs_hit, obs_way, obs_dirty} !== {exp_hit, exp_way, exp_dirty})
          $display("FAIL rand_resp addr %h got %b want %b", a, {obs_hit, obs_way, obs_dirty}, {exp_hit, exp_way, exp_dirty});
        else n_pass++;
        n_checks++;
        if ({obs_vway, obs_vvalid, obs_vdirty} !== {exp_vway, exp_vvalid, exp_vdirty})
          $display("FAIL rand_victim addr %h got %b want %b", a, {obs_vway, obs_vvalid, obs_vdirty}, {exp_vway, exp_vvalid, exp_vdirty});
        else n_pass++;
        if (exp_vtag_known) begin
          n_checks++;
          if (obs_vtag !== exp_vtag) $display("FAIL rand_victim_tag addr %h got %h want %h", a, obs_vtag, exp_vtag);
          else n_pass++;
        end
      end else begin
        do_update(a, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
  endtask

  task automatic test_flush_and_reset();
    int n;
    bit bad;
    do_update(32'h0000_5080, 0, 1'b1, 1'b1);
    do_update(32'hFFFF_FFC0, 1, 1'b1, 1'b1);
    do_lookup(32'hFFFF_FFC0);
    n_checks++; if (obs_hit !== 1'b1) $display("FAIL prefill_hit got %0b want 1", obs_hit); else n_pass++;
    // flush, with a second flush pulse mid-sweep that must be ignored
    @(posedge clk_i); #1; flush_i = 1'b1;
    @(posedge clk_i); #1; flush_i = 1'b0;
    n = 0; bad = 1'b0;
    while (busy_o === 1'b1 && n < 200) begin
      if (lookup_ready_o !== 1'b0) bad = 1'b1;
      n++;
      flush_i = (n == 10);
      @(posedge clk_i); #1;
    end
    flush_i = 1'b0;
    n_checks++; if (n != 64) $display("FAIL flush_sweep_len got %0d want 64", n); else n_pass++;
    n_checks++; if (bad) $display("FAIL flush_ready_during_sweep got 1 want 0"); else n_pass++;
    model_sweep();
    // reset at sweep cycle 30 restarts the whole sweep
    @(posedge clk_i); #1; flush_i = 1'b1;
    @(posedge clk_i); #1; flush_i = 1'b0;
    n = 0;
    while (busy_o === 1'b1 && n < 30) begin
      n++;
      @(posedge clk_i); #1;
    end
    n_checks++; if (n != 30) $display("FAIL sweep_reach_30 got %0d want 30", n); else n_pass++;
    rst_ni = 1'b0;
    #1;
    n_checks++; if ({busy_o, resp_valid_o} !== 2'b10) $display("FAIL midsweep_reset got busy %0b rv %0b want 1 0", busy_o, resp_valid_o); else n_pass++;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    n = 0;
    while (busy_o === 1'b1 && n < 200) begin
      n++;
      @(posedge clk_i); #1;
    end
    n_checks++; if (n != 64) $display("FAIL restart_sweep_len got %0d want 64", n); else n_pass++;
    // reset while a lookup is presented: no response may appear
    lookup_valid_i = 1'b1; lookup_addr_i = 32'h0000_1040;
    #1;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    n_checks++; if (resp_valid_o !== 1'b0) $display("FAIL reset_lookup_resp got %0b want 0", resp_valid_o); else n_pass++;
    lookup_valid_i = 1'b0;
    rst_ni = 1'b1;
    n = 0;
    while (busy_o === 1'b1 && n < 200) begin
      n++;
      @(posedge clk_i); #1;
    end
    n_checks++; if (n != 64) $display("FAIL post_reset_sweep_len got %0d want 64", n); else n_pass++;
    model_sweep();
    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0: do_lookup(32'h0000_5080);
        1: do_lookup(32'hFFFF_FFC0);
        2: do_lookup(32'h0000_1040);
        default: do_lookup(32'h0000_7140);
      endcase
      n_checks++;
      if ({obs_rv, obs_hit, obs_vvalid} !== 3'b100)
        $display("FAIL after_flush_miss got rv %0b hit %0b vvalid %0b want 1 0 0", obs_rv, obs_hit, obs_vvalid);
      else n_pass++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_miss_after_init();
    test_hit_dirty();
    test_plru_victim();
    test_back_to_back();
    test_hold();
    test_random();
    test_flush_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache_tag_array.md
DCACHE_TAG_ARRAY -- requirements
Module: dcache_tag_array

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-002 The block SHALL have parameter SETS, default 64, meaning set count (power of 2, 2..1024).
REQ-003 The block SHALL have parameter WAYS, default 2, meaning associativity (1, 2 or 4).
REQ-004 The block SHALL have parameter LINE_BYTES, default 64, meaning line size (power of 2).
REQ-005 Derived widths SHALL be: OFF_W=log2(LINE_BYTES), IDX_W=log2(SETS), TAG_W=ADDR_WIDTH-IDX_W-OFF_W, WAY_W=max(1,log2(WAYS)).
REQ-006 clk_i  in  1  single clock; all state on rising edge.
REQ-007 rst_ni  in  1  asynchronous, active-low reset.
REQ-008 lookup_valid_i  in  1  lookup request.
REQ-009 lookup_addr_i  in  ADDR_WIDTH  lookup address.
REQ-010 lookup_ready_o  out  1  lookup accepted when valid&ready.
REQ-011 resp_valid_o  out  1  response strobe, one cycle.
REQ-012 resp_hit_o / resp_way_o / resp_dirty_o  out  1 / WAY_W / 1  hit flag, hit way, dirty bit of hit way.
REQ-013 victim_way_o / victim_valid_o / victim_dirty_o / victim_tag_o  out  WAY_W / 1 / 1 / TAG_W  replacement candidate for the looked-up set.
REQ-014 upd_valid_i  in  1  tag-entry write strobe.
REQ-015 upd_addr_i / upd_way_i / upd_vbit_i / upd_dbit_i  in  ADDR_WIDTH / WAY_W / 1 / 1  entry address, way, new valid, new dirty.
REQ-016 flush_i  in  1  single-cycle pulse: invalidate all entries.
REQ-017 busy_o  out  1  high while init/flush sweep runs.

Function
REQ-018 Entry SHALL hold {dirty, valid, tag}; index=addr[OFF_W+IDX_W-1:OFF_W], tag=addr[ADDR_WIDTH-1:OFF_W+IDX_W].
REQ-019 FSM states SHALL be SWEEP and READY; reset enters SWEEP with index counter 0.
REQ-020 In SWEEP, one set per cycle SHALL be cleared (all ways valid=0, dirty=0, PLRU=0); after set SETS-1 the FSM SHALL enter READY (sweep takes exactly SETS cycles).
REQ-021 flush_i in READY SHALL enter SWEEP with counter 0 next cycle; flush_i during SWEEP SHALL be ignored; dirty lines are discarded (writeback is the controller's duty).
REQ-022 lookup_ready_o SHALL be 1 only in READY and when upd_valid_i=0 (update has priority).
REQ-023 Accepted lookup SHALL produce resp_valid_o exactly 1 cycle later, all response/victim fields reflecting array state at the accept edge.
REQ-024 Hit = any way with valid=1 and matching tag; resp_way_o = lowest such way; resp_way_o and resp_dirty_o SHALL be 0 on miss.
REQ-025 Victim SHALL be lowest-index invalid way if any, else the PLRU way; victim_valid/dirty/tag SHALL be that way's stored fields.
REQ-026 PLRU SHALL be per-set tree-PLRU (WAYS-1 bits; none for WAYS=1); a hit SHALL mark the hit way most-recent; an update with upd_vbit_i=1 SHALL mark upd_way_i most-recent; misses do not change PLRU.
REQ-027 upd_valid_i in READY SHALL write {upd_dbit_i, upd_vbit_i, tag(upd_addr_i)} to (index, upd_way_i) at the edge; upd_valid_i in SWEEP SHALL be dropped.
REQ-028 Outputs not qualified by resp_valid_o SHALL hold last values.

Reset
REQ-029 Reset SHALL force: FSM=SWEEP, counter=0, busy_o=1, lookup_ready_o=0, resp_valid_o=0, all response/victim outputs 0.
REQ-030 Reset asserted mid-sweep or mid-lookup SHALL abort it; the pending response is never issued and the sweep restarts from set 0.
REQ-031 Tag storage itself SHALL need no reset (cleared by sweep).

Structure
REQ-032 A shared package dcache_pkg SHALL hold derived-width functions, entry field positions and the FSM state encoding.
REQ-033 One sub-module dcache_plru (combinational victim select and update per set, parametrised by WAYS) SHALL be instantiated.

Verification (SETS=64, WAYS=2, LINE_BYTES=64)
REQ-034 Release reset -> busy_o=1 for exactly 64 cycles, lookup_ready_o=0 throughout, then 1.
REQ-035 Lookup 0x0000_1040 after init -> miss, victim_way_o=0, victim_valid_o=0.
REQ-036 Update 0x0000_1040 way 1 v=1 d=1, lookup 0x0000_1040 -> hit, way 1, dirty 1; lookup 0x0000_2040 -> miss, victim way 0.
REQ-037 Fill set 1 ways 0,1 (tags 0x1, 0x2), hit tag 0x1, lookup tag 0x3 -> victim_way_o=1, victim_tag_o=0x00002.
REQ-038 upd_valid_i and lookup_valid_i same cycle -> lookup_ready_o=0, update applied, lookup accepted next cycle.
REQ-039 flush_i after fills -> 64-cycle sweep; rst_ni low at sweep cycle 30 -> sweep restarts, full 64 cycles; all subsequent lookups miss.
